// File: rtl/sum_ctrl_pkg.sv
// Shared definitions for the sum(1..10) control unit: FSM states and
// register-file address map.
package sum_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_INIT_I   = 4'd1,
        S_INIT_SUM = 4'd2,
        S_LOAD_ONE = 4'd3,
        S_CHECK    = 4'd4,
        S_ADD      = 4'd5,
        S_INC      = 4'd6,
        S_OUT      = 4'd7,
        S_DONE     = 4'd8,
        S_ERROR    = 4'd9
    } state_t;

    // Register map: R0 reads as zero, R1 = i, R2 = sum, R3 = constant 1
    localparam logic [1:0] REG_ZERO = 2'd0;
    localparam logic [1:0] REG_I    = 2'd1;
    localparam logic [1:0] REG_SUM  = 2'd2;
    localparam logic [1:0] REG_ONE  = 2'd3;

    // Loop bound evaluated by the datapath comparator (i <= LOOP_LIMIT)
    localparam int unsigned LOOP_LIMIT = 10;

endpackage

// File: rtl/sum_ctrl_watchdog.sv
// Iteration counter for the control unit: cleared at run start, bumped on
// each ADD, saturating at MAX_ITER, with an equality flag for the FSM.
module sum_ctrl_watchdog #(
    parameter int unsigned MAX_ITER = 16,
    parameter int unsigned ITER_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              incr,
    output logic [ITER_W-1:0] count,
    output logic              at_max
);

    localparam logic [ITER_W-1:0] MAX_VAL = ITER_W'(MAX_ITER);

    logic [ITER_W-1:0] count_q;
    logic [ITER_W-1:0] count_d;

    // Next count: clear wins, increment stops at the limit
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (incr && (count_q != MAX_VAL)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count  = count_q;
    assign at_max = (count_q == MAX_VAL);

endmodule

// File: rtl/sum_control_unit.sv
// Moore control unit sequencing the register-file datapath to compute
// sum(i), i=1..10, with start/busy/done handshake and an iteration watchdog.
module sum_control_unit
    import sum_ctrl_pkg::*;
#(
    parameter int unsigned MAX_ITER = 16,
    parameter int unsigned ITER_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              iLe10,
    output logic              rfsrcmuxsel,
    output logic              rfwe,
    output logic [1:0]        waddr,
    output logic [1:0]        raddr1,
    output logic [1:0]        raddr2,
    output logic              outLoad,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ITER_W-1:0] iter_count
);

    state_t state_q;
    state_t state_d;
    logic   wd_at_max;

    sum_ctrl_watchdog #(
        .MAX_ITER (MAX_ITER),
        .ITER_W   (ITER_W)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clr    (state_q == S_INIT_I),
        .incr   (state_q == S_ADD),
        .count  (iter_count),
        .at_max (wd_at_max)
    );

    // State register; async reset forces IDLE so all decoded outputs drop at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; unused encodings fall back to IDLE
    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:     state_d = start ? S_INIT_I : S_IDLE;
            S_INIT_I:   state_d = S_INIT_SUM;
            S_INIT_SUM: state_d = S_LOAD_ONE;
            S_LOAD_ONE: state_d = S_CHECK;
            S_CHECK: begin
                if (!iLe10) begin
                    state_d = S_DONE;
                end else if (wd_at_max) begin
                    state_d = S_ERROR;
                end else begin
                    state_d = S_ADD;
                end
            end
            S_ADD:      state_d = S_INC;
            S_INC:      state_d = S_OUT;
            S_OUT:      state_d = S_CHECK;
            S_DONE:     state_d = S_IDLE;
            S_ERROR:    state_d = start ? S_INIT_I : S_ERROR;
            default:    state_d = S_IDLE;
        endcase
    end

    // Moore output decode: every datapath control is a function of state only
    always_comb begin
        rfsrcmuxsel = 1'b0;
        rfwe        = 1'b0;
        waddr       = REG_ZERO;
        raddr1      = REG_ZERO;
        raddr2      = REG_ZERO;
        outLoad     = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        error       = 1'b0;
        case (state_q)
            S_INIT_I: begin
                rfsrcmuxsel = 1'b1;
                rfwe        = 1'b1;
                waddr       = REG_I;
                busy        = 1'b1;
            end
            S_INIT_SUM: begin
                rfwe        = 1'b1;
                waddr       = REG_SUM;
                busy        = 1'b1;
            end
            S_LOAD_ONE: begin
                rfsrcmuxsel = 1'b1;
                rfwe        = 1'b1;
                waddr       = REG_ONE;
                busy        = 1'b1;
            end
            S_CHECK: begin
                raddr1      = REG_I;
                busy        = 1'b1;
            end
            S_ADD: begin
                rfwe        = 1'b1;
                waddr       = REG_SUM;
                raddr1      = REG_I;
                raddr2      = REG_SUM;
                busy        = 1'b1;
            end
            S_INC: begin
                rfwe        = 1'b1;
                waddr       = REG_I;
                raddr1      = REG_I;
                raddr2      = REG_ONE;
                busy        = 1'b1;
            end
            S_OUT: begin
                raddr1      = REG_SUM;
                outLoad     = 1'b1;
                busy        = 1'b1;
            end
            S_DONE:  done  = 1'b1;
            S_ERROR: error = 1'b1;
            default: ;
        endcase
    end

endmodule
